// File: rtl/edl_token_ctrl_sync.sv
// Synchronous error-detecting-latch token controller: latch window, sample window,
// dual-rail error resolution, stall/replay recovery and 4-phase left/right handshakes.
module edl_token_ctrl_sync #(
  parameter int DELAY_B   = 5,
  parameter int DELAY_E   = 5,
  parameter int RECOV_CYC = 2,
  parameter int MAX_RETRY = 3,
  parameter int MODE      = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             l_req,
  output logic             l_ack,
  output logic             r_req,
  input  logic             r_ack,
  output logic             le_req,
  input  logic             le_ack,
  input  logic             err1,
  input  logic             err0,
  output logic             latch_en,
  output logic             sample,
  output logic             err_out,
  output logic             stall,
  output logic             fatal,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MAX_AB = (DELAY_B > DELAY_E) ? DELAY_B : DELAY_E;
  localparam int MAX_D  = (MAX_AB > RECOV_CYC) ? MAX_AB : RECOV_CYC;
  localparam int CW     = $clog2(MAX_D + 1);
  localparam int RW     = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] LAST_B = CW'(DELAY_B - 1);
  localparam logic [CW-1:0] LAST_E = CW'(DELAY_E - 1);
  localparam logic [CW-1:0] LAST_R = CW'(RECOV_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    SAMP  = 3'd2,
    RECOV = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [RW-1:0] retry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      retry_reg <= '0;
      l_ack     <= 1'b0;
      r_req     <= 1'b0;
      le_req    <= 1'b0;
      latch_en  <= 1'b0;
      sample    <= 1'b0;
      err_out   <= 1'b0;
      stall     <= 1'b0;
      fatal     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      le_req  <= l_req;
      err_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (l_req && le_ack && !r_ack) begin
            state_reg <= OPEN;
            latch_en  <= 1'b1;
            cnt_reg   <= '0;
            retry_reg <= '0;
          end
        end
        OPEN: begin
          if (cnt_reg == LAST_B) begin
            state_reg <= SAMP;
            latch_en  <= 1'b0;
            sample    <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SAMP: begin
          if (cnt_reg == LAST_E) begin
            sample  <= 1'b0;
            cnt_reg <= '0;
            // Rails are only trusted at the close of the window; pending counts as an error.
            case ({err1, err0})
              2'b01: begin
                state_reg <= DONE;
                l_ack     <= 1'b1;
                r_req     <= 1'b1;
              end
              2'b11: begin
                state_reg <= FAULT;
                fatal     <= 1'b1;
              end
              default: begin
                state_reg <= RECOV;
                err_out   <= 1'b1;
                stall     <= 1'b1;
                if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
              end
            endcase
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RECOV: begin
          if (cnt_reg == LAST_R) begin
            stall   <= 1'b0;
            cnt_reg <= '0;
            if (retry_reg == RETRY_LIMIT) begin
              state_reg <= FAULT;
              fatal     <= 1'b1;
            end else begin
              retry_reg <= retry_reg + 1'b1;
              if (MODE == 1) begin
                state_reg <= OPEN;
                latch_en  <= 1'b1;
              end else begin
                state_reg <= SAMP;
                sample    <= 1'b1;
              end
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // Left and right sides return to zero independently.
          if (l_ack && !l_req && !le_ack) l_ack <= 1'b0;
          if (r_req && r_ack) r_req <= 1'b0;
          if (!l_ack && !r_req && !r_ack) state_reg <= IDLE;
        end
        FAULT: begin
          fatal    <= 1'b1;
          latch_en <= 1'b0;
          sample   <= 1'b0;
          l_ack    <= 1'b0;
          r_req    <= 1'b0;
          stall    <= 1'b0;
        end
        default: begin
          state_reg <= FAULT;
          fatal     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edl_token_ctrl_sync.sv
// Directed bench for edl_token_ctrl_sync: default, MODE=0 and CNT_W=2 instances
// share stimulus; each scenario checks only the instance it targets.
module tb_edl_token_ctrl_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic l_req = 1'b0, r_ack = 1'b0, le_ack = 1'b0, err1 = 1'b0, err0 = 1'b0;

  logic a_l_ack, a_r_req, a_le_req, a_latch_en, a_sample, a_err_out, a_stall, a_fatal;
  logic [7:0] a_err_cnt;
  logic b_l_ack, b_r_req, b_le_req, b_latch_en, b_sample, b_err_out, b_stall, b_fatal;
  logic [7:0] b_err_cnt;
  logic c_l_ack, c_r_req, c_le_req, c_latch_en, c_sample, c_err_out, c_stall, c_fatal;
  logic [1:0] c_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  edl_token_ctrl_sync dut_a (
    .clk(clk), .rst_n(rst_n), .l_req(l_req), .l_ack(a_l_ack), .r_req(a_r_req),
    .r_ack(r_ack), .le_req(a_le_req), .le_ack(le_ack), .err1(err1), .err0(err0),
    .latch_en(a_latch_en), .sample(a_sample), .err_out(a_err_out), .stall(a_stall),
    .fatal(a_fatal), .err_cnt(a_err_cnt)
  );

  edl_token_ctrl_sync #(.MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .l_req(l_req), .l_ack(b_l_ack), .r_req(b_r_req),
    .r_ack(r_ack), .le_req(b_le_req), .le_ack(le_ack), .err1(err1), .err0(err0),
    .latch_en(b_latch_en), .sample(b_sample), .err_out(b_err_out), .stall(b_stall),
    .fatal(b_fatal), .err_cnt(b_err_cnt)
  );

  edl_token_ctrl_sync #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .l_req(l_req), .l_ack(c_l_ack), .r_req(c_r_req),
    .r_ack(r_ack), .le_req(c_le_req), .le_ack(le_ack), .err1(err1), .err0(err0),
    .latch_en(c_latch_en), .sample(c_sample), .err_out(c_err_out), .stall(c_stall),
    .fatal(c_fatal), .err_cnt(c_err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    l_req = 1'b0; le_ack = 1'b0; r_ack = 1'b0;
    {err1, err0} = 2'b01;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({a_l_ack, a_r_req, a_le_req, a_latch_en, a_sample, a_err_out, a_stall, a_fatal} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {a_l_ack, a_r_req, a_le_req, a_latch_en, a_sample, a_err_out, a_stall, a_fatal});
    end
    n_cmp++;
    if (a_err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_err_cnt: got %0d want 0", a_err_cnt);
    end
    $display("reset: outputs=%b err_cnt=%0d",
             {a_l_ack, a_r_req, a_le_req, a_latch_en, a_sample, a_err_out, a_stall, a_fatal}, a_err_cnt);
  endtask

  task automatic test_clean();
    int lat, smp, ovl, first_lack, first_rreq;
    lat = 0; smp = 0; ovl = 0; first_lack = 0; first_rreq = 0;
    do_reset();
    {err1, err0} = 2'b01;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        n_cmp++;
        if (a_le_req !== 1'b1) begin
          n_bad++;
          $display("FAIL clean_le_req: got %b want 1", a_le_req);
        end
      end
      if (a_latch_en) lat++;
      if (a_sample) smp++;
      if (a_latch_en && a_sample) ovl++;
      if (a_l_ack && first_lack == 0) first_lack = i;
      if (a_r_req && first_rreq == 0) first_rreq = i;
    end
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL clean_latch_cycles: got %0d want 5", lat); end
    n_cmp++;
    if (smp !== 5) begin n_bad++; $display("FAIL clean_sample_cycles: got %0d want 5", smp); end
    n_cmp++;
    if (ovl !== 0) begin n_bad++; $display("FAIL clean_overlap: got %0d want 0", ovl); end
    n_cmp++;
    if (first_lack !== 11) begin n_bad++; $display("FAIL clean_l_ack_latency: got %0d want 11", first_lack); end
    n_cmp++;
    if (first_rreq !== 11) begin n_bad++; $display("FAIL clean_r_req_latency: got %0d want 11", first_rreq); end
    // left return-to-zero first
    l_req = 1'b0; le_ack = 1'b0;
    tick();
    n_cmp++;
    if ({a_l_ack, a_r_req} !== 2'b01) begin
      n_bad++;
      $display("FAIL clean_left_rtz: got l_ack,r_req=%b want 01", {a_l_ack, a_r_req});
    end
    r_ack = 1'b1;
    tick();
    n_cmp++;
    if (a_r_req !== 1'b0) begin n_bad++; $display("FAIL clean_right_rtz: got %b want 0", a_r_req); end
    r_ack = 1'b0;
    tick();
    l_req = 1'b1; le_ack = 1'b1;
    tick();
    n_cmp++;
    if (a_latch_en !== 1'b1) begin n_bad++; $display("FAIL clean_back_to_idle: latch_en got %b want 1", a_latch_en); end
    n_cmp++;
    if (a_err_cnt !== 8'd0) begin n_bad++; $display("FAIL clean_err_cnt: got %0d want 0", a_err_cnt); end
    $display("clean: latch=%0d sample=%0d l_ack_at=%0d err_cnt=%0d", lat, smp, first_lack, a_err_cnt);
  endtask

  task automatic test_rtz_right_first();
    int got;
    got = 0;
    do_reset();
    {err1, err0} = 2'b01;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    for (int i = 1; i <= 30 && got == 0; i++) begin
      tick();
      if (a_l_ack) got = i;
    end
    n_cmp++;
    if (got !== 11) begin n_bad++; $display("FAIL rtzr_l_ack_latency: got %0d want 11", got); end
    r_ack = 1'b1;
    tick();
    n_cmp++;
    if ({a_l_ack, a_r_req} !== 2'b10) begin
      n_bad++;
      $display("FAIL rtzr_right_first: got l_ack,r_req=%b want 10", {a_l_ack, a_r_req});
    end
    r_ack = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (a_l_ack !== 1'b1) begin n_bad++; $display("FAIL rtzr_left_held: got %b want 1", a_l_ack); end
    l_req = 1'b0; le_ack = 1'b0;
    tick();
    n_cmp++;
    if (a_l_ack !== 1'b0) begin n_bad++; $display("FAIL rtzr_left_rtz: got %b want 0", a_l_ack); end
    tick();
    l_req = 1'b1; le_ack = 1'b1;
    tick();
    n_cmp++;
    if (a_latch_en !== 1'b1) begin n_bad++; $display("FAIL rtzr_back_to_idle: latch_en got %b want 1", a_latch_en); end
    $display("rtz_right_first: l_ack_at=%0d latch_en_after=%b", got, a_latch_en);
  endtask

  task automatic test_replay();
    int lat, smp, stl, pulses, first_lack;
    lat = 0; smp = 0; stl = 0; pulses = 0; first_lack = 0;
    do_reset();
    {err1, err0} = 2'b10;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    for (int i = 1; i <= 40 && first_lack == 0; i++) begin
      tick();
      if (a_latch_en) lat++;
      if (a_sample) smp++;
      if (a_stall) stl++;
      if (a_err_out) begin pulses++; {err1, err0} = 2'b01; end
      if (a_l_ack) first_lack = i;
    end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL replay_err_out: got %0d want 1", pulses); end
    n_cmp++;
    if (stl !== 2) begin n_bad++; $display("FAIL replay_stall: got %0d want 2", stl); end
    n_cmp++;
    if (lat !== 10) begin n_bad++; $display("FAIL replay_latch_cycles: got %0d want 10", lat); end
    n_cmp++;
    if (smp !== 10) begin n_bad++; $display("FAIL replay_sample_cycles: got %0d want 10", smp); end
    n_cmp++;
    if (first_lack !== 23) begin n_bad++; $display("FAIL replay_l_ack_latency: got %0d want 23", first_lack); end
    n_cmp++;
    if (a_err_cnt !== 8'd1) begin n_bad++; $display("FAIL replay_err_cnt: got %0d want 1", a_err_cnt); end
    $display("replay: pulses=%0d stall=%0d latch=%0d sample=%0d l_ack_at=%0d err_cnt=%0d",
             pulses, stl, lat, smp, first_lack, a_err_cnt);
  endtask

  task automatic test_resample();
    int lat, smp, stl, pulses, first_lack;
    lat = 0; smp = 0; stl = 0; pulses = 0; first_lack = 0;
    do_reset();
    {err1, err0} = 2'b00;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    for (int i = 1; i <= 40 && first_lack == 0; i++) begin
      tick();
      if (b_latch_en) lat++;
      if (b_sample) smp++;
      if (b_stall) stl++;
      if (b_err_out) begin pulses++; {err1, err0} = 2'b01; end
      if (b_l_ack) first_lack = i;
    end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL resample_err_out: got %0d want 1", pulses); end
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL resample_latch_cycles: got %0d want 5", lat); end
    n_cmp++;
    if (smp !== 10) begin n_bad++; $display("FAIL resample_sample_cycles: got %0d want 10", smp); end
    n_cmp++;
    if (stl !== 2) begin n_bad++; $display("FAIL resample_stall: got %0d want 2", stl); end
    n_cmp++;
    if (first_lack !== 18) begin n_bad++; $display("FAIL resample_l_ack_latency: got %0d want 18", first_lack); end
    n_cmp++;
    if (b_err_cnt !== 8'd1) begin n_bad++; $display("FAIL resample_err_cnt: got %0d want 1", b_err_cnt); end
    $display("resample: pulses=%0d latch=%0d sample=%0d l_ack_at=%0d err_cnt=%0d",
             pulses, lat, smp, first_lack, b_err_cnt);
  endtask

  task automatic test_retry_exhaust();
    int pulses, first_fatal, lack_seen;
    pulses = 0; first_fatal = 0; lack_seen = 0;
    do_reset();
    {err1, err0} = 2'b10;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (a_err_out) pulses++;
      if (a_l_ack) lack_seen++;
      if (a_fatal && first_fatal == 0) first_fatal = i;
    end
    n_cmp++;
    if (pulses !== 4) begin n_bad++; $display("FAIL retry_err_out: got %0d want 4", pulses); end
    n_cmp++;
    if (first_fatal !== 49) begin n_bad++; $display("FAIL retry_fatal_cycle: got %0d want 49", first_fatal); end
    n_cmp++;
    if (lack_seen !== 0) begin n_bad++; $display("FAIL retry_l_ack: got %0d cycles want 0", lack_seen); end
    n_cmp++;
    if (a_err_cnt !== 8'd4) begin n_bad++; $display("FAIL retry_err_cnt: got %0d want 4", a_err_cnt); end
    {err1, err0} = 2'b01; l_req = 1'b0; le_ack = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({a_fatal, a_latch_en, a_sample, a_l_ack, a_r_req} !== 5'b10000) begin
      n_bad++;
      $display("FAIL retry_fault_sticky: got %b want 10000", {a_fatal, a_latch_en, a_sample, a_l_ack, a_r_req});
    end
    $display("retry_exhaust: pulses=%0d fatal_at=%0d err_cnt=%0d", pulses, first_fatal, a_err_cnt);
  endtask

  task automatic test_illegal_and_reset();
    int first_fatal, pulses;
    first_fatal = 0; pulses = 0;
    do_reset();
    {err1, err0} = 2'b11;
    l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (a_err_out) pulses++;
      if (a_fatal && first_fatal == 0) first_fatal = i;
    end
    n_cmp++;
    if (first_fatal !== 11) begin n_bad++; $display("FAIL illegal_fatal_cycle: got %0d want 11", first_fatal); end
    n_cmp++;
    if (pulses !== 0 || a_err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL illegal_no_error: got pulses=%0d err_cnt=%0d want 0 0", pulses, a_err_cnt);
    end
    do_reset();
    {err1, err0} = 2'b01;
    l_req = 1'b1; le_ack = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (a_latch_en !== 1'b1) begin n_bad++; $display("FAIL midopen_latch_en: got %b want 1", a_latch_en); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_l_ack, a_r_req, a_le_req, a_latch_en, a_sample, a_stall, a_fatal} !== 7'd0) begin
      n_bad++;
      $display("FAIL async_reset_clear: got %b want 0000000",
               {a_l_ack, a_r_req, a_le_req, a_latch_en, a_sample, a_stall, a_fatal});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (a_latch_en !== 1'b1) begin n_bad++; $display("FAIL after_reset_restart: latch_en got %b want 1", a_latch_en); end
    $display("illegal_and_reset: fatal_at=%0d latch_en_after=%b", first_fatal, a_latch_en);
  endtask

  task automatic test_saturate();
    int got;
    do_reset();
    for (int t = 1; t <= 5; t++) begin
      got = 0;
      {err1, err0} = 2'b10;
      l_req = 1'b1; le_ack = 1'b1; r_ack = 1'b0;
      for (int i = 1; i <= 60 && got == 0; i++) begin
        tick();
        if (c_err_out) {err1, err0} = 2'b01;
        if (c_l_ack) got = i;
      end
      n_cmp++;
      if (got == 0) begin n_bad++; $display("FAIL sat_token%0d_timeout: got no l_ack want l_ack", t); end
      // both sides return to zero in the same cycle
      l_req = 1'b0; le_ack = 1'b0; r_ack = 1'b1;
      tick();
      r_ack = 1'b0;
      tick();
      n_cmp++;
      if (c_err_cnt !== ((t > 3) ? 2'd3 : 2'(t))) begin
        n_bad++;
        $display("FAIL sat_err_cnt_token%0d: got %0d want %0d", t, c_err_cnt, (t > 3) ? 3 : t);
      end
      $display("saturate: token=%0d l_ack_at=%0d err_cnt=%0d", t, got, c_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_rtz_right_first();
    test_replay();
    test_resample();
    test_retry_exhaust();
    test_illegal_and_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
